// File: rtl/clk_meter.sv
// Gated edge counter and period tracker for a slow asynchronous signal.
// The signal is synchronised into clk_in; the FSM runs measurement windows while the period tracker runs continuously.
module clk_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             ovf,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic             period_ok
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_DONE} state_t;

  state_t           r_state;
  logic [GW-1:0]    r_gcnt;
  logic [CNT_W-1:0] r_acc;
  logic             r_iovf;
  logic [CNT_W-1:0] r_pcnt;
  logic             r_seen;
  logic             r_s1, r_s2, r_s3;

  logic             w_rise;
  logic [CNT_W-1:0] w_acc_nx;
  logic             w_ovf_nx;

  assign w_rise = r_s2 & ~r_s3;

  always_comb begin
    w_acc_nx = r_acc;
    if (w_rise && (r_acc != '1))
      w_acc_nx = r_acc + 1'b1;
    w_ovf_nx = r_iovf | (&w_acc_nx);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gcnt   <= '0;
      r_acc    <= '0;
      r_iovf   <= 1'b0;
      busy     <= 1'b0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          valid <= 1'b0;
          if (start || cont) begin
            r_state <= S_GATE;
            r_gcnt  <= '0;
            r_acc   <= '0;
            r_iovf  <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_GATE: begin
          r_acc  <= w_acc_nx;
          r_iovf <= w_ovf_nx;
          r_gcnt <= r_gcnt + 1'b1;
          // Results are latched on the last gate edge so valid and edge_cnt are visible during DONE.
          if (r_gcnt == GLAST) begin
            r_state  <= S_DONE;
            edge_cnt <= w_acc_nx;
            ovf      <= w_ovf_nx;
            valid    <= 1'b1;
          end
        end
        S_DONE: begin
          valid  <= 1'b0;
          r_gcnt <= '0;
          r_acc  <= '0;
          r_iovf <= 1'b0;
          if (cont) begin
            r_state <= S_GATE;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt    <= '0;
      r_seen    <= 1'b0;
      period    <= '0;
      period_ok <= 1'b0;
    end else if (w_rise) begin
      period <= r_pcnt;
      r_pcnt <= CNT_W'(1);
      r_seen <= 1'b1;
      if (r_seen)
        period_ok <= 1'b1;
    end else if (r_pcnt != '1) begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_meter.sv
// Bench for clk_meter: a 32-bit and a 4-bit instance share stimulus and are checked every cycle against a behavioural model.
module tb_clk_meter;

  localparam int unsigned G = 100;
  localparam longint M32 = 64'hFFFF_FFFF;
  localparam longint M4  = 15;

  logic clk_in = 1'b0;
  logic rst_n, sig_in, start, cont;

  logic        busy_a, ovf_a, valid_a, pok_a;
  logic [31:0] edge_a, period_a;
  logic        busy_b, ovf_b, valid_b, pok_b;
  logic [3:0]  edge_b, period_b;

  always #5 clk_in = ~clk_in;

  clk_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy_a), .edge_cnt(edge_a), .ovf(ovf_a), .valid(valid_a),
    .period(period_a), .period_ok(pok_a)
  );

  clk_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy_b), .edge_cnt(edge_b), .ovf(ovf_b), .valid(valid_b),
    .period(period_b), .period_ok(pok_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Model state: samples of sig_in per edge, rise timestamps, and the gate's progress.
  bit     sq[$];
  longint k, last_rise, m_ecnt, m_period, gcount;
  int     nrises, mphase, gpos;
  bit     m_busy, m_valid, m_pok;

  // Square-wave generator: per 0 holds lvl, per 1 gives random bits.
  int sq_per = 0;
  int sq_ph  = 0;
  bit sq_lvl = 1'b0;

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; last_rise = 1; nrises = 0;
    sq = {1'b0, 1'b0, 1'b0};
    mphase = 0; gpos = 0; gcount = 0;
    m_busy = 0; m_valid = 0; m_ecnt = 0; m_period = 0; m_pok = 0;
  endtask

  task automatic model_step();
    bit rise;
    k++;
    rise = sq[1] && !sq[0];
    sq.push_back(sig_in);
    void'(sq.pop_front());
    if (rise) begin
      nrises++;
      m_period = k - last_rise;
      last_rise = k;
      if (nrises >= 2) m_pok = 1;
    end
    case (mphase)
      0: begin
        m_valid = 0;
        if (start || cont) begin
          mphase = 1; gpos = 0; gcount = 0; m_busy = 1;
        end
      end
      1: begin
        if (rise) gcount++;
        gpos++;
        if (gpos == G) begin
          mphase = 2; m_ecnt = gcount; m_valid = 1;
        end
      end
      default: begin
        m_valid = 0;
        if (cont) begin
          mphase = 1; gpos = 0; gcount = 0;
        end else begin
          mphase = 0; m_busy = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("busy_a",   busy_a,   m_busy);
    chk("valid_a",  valid_a,  m_valid);
    chk("ecnt_a",   edge_a,   sat(m_ecnt, M32));
    chk("ovf_a",    ovf_a,    (m_ecnt >= M32) ? 1 : 0);
    chk("period_a", period_a, sat(m_period, M32));
    chk("pok_a",    pok_a,    m_pok);
    chk("busy_b",   busy_b,   m_busy);
    chk("valid_b",  valid_b,  m_valid);
    chk("ecnt_b",   edge_b,   sat(m_ecnt, M4));
    chk("ovf_b",    ovf_b,    (m_ecnt >= M4) ? 1 : 0);
    chk("period_b", period_b, sat(m_period, M4));
    chk("pok_b",    pok_b,    m_pok);
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk_in);
    compare_all();
    if (sq_per == 0) sig_in = sq_lvl;
    else if (sq_per == 1) sig_in = 1'($urandom_range(1, 0));
    else begin
      sig_in = (sq_ph < sq_per / 2);
      sq_ph = (sq_ph + 1) % sq_per;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Caller sets start/cont first; returns cycles counting the sampling edge as 1.
  task automatic wait_valid(input int pulse_at, output int cycles);
    bit found;
    found = 0;
    cycles = 0;
    while (!found && cycles < 300) begin
      tick();
      cycles++;
      start = (cycles == pulse_at);
      if (valid_a) found = 1;
    end
    if (!found) chk("valid_timeout", 0, 1);
  endtask

  task automatic set_wave(input int per, input bit lvl);
    sq_per = per; sq_lvl = lvl; sq_ph = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy_a | busy_b, 0);
    chk({tag, "_valid"}, valid_a | valid_b, 0);
    chk({tag, "_ecnt"}, edge_a | 32'(edge_b), 0);
    chk({tag, "_ovf"}, ovf_a | ovf_b, 0);
    chk({tag, "_period"}, period_a | 32'(period_b), 0);
    chk({tag, "_pok"}, pok_a | pok_b, 0);
  endtask

  initial begin
    int c;
    int nval;
    rst_n = 1'b0; sig_in = 1'b0; start = 1'b0; cont = 1'b0;
    model_reset();
    ticks(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single shot at period 10 with a stray start mid-gate.
    set_wave(10, 0);
    ticks(30);
    start = 1'b1;
    wait_valid(30, c);
    chk("lat_single", c, 101);
    chk("t1_ecnt_a", edge_a, 10);
    chk("t1_ovf_a", ovf_a, 0);
    chk("t1_period_a", period_a, 10);
    chk("t1_pok_a", pok_a, 1);
    chk("t1_ecnt_b", edge_b, 10);
    nval = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (valid_a) nval++;
    end
    chk("t1_extra_valid", nval, 0);

    // Continuous mode, then drop cont mid-gate.
    cont = 1'b1;
    wait_valid(-1, c);
    chk("lat_cont0", c, 101);
    wait_valid(-1, c);
    chk("lat_cont1", c, 101);
    chk("t2_ecnt_a", edge_a, 10);
    ticks(40);
    cont = 1'b0;
    wait_valid(-1, c);
    chk("lat_cont_drop", c, 61);
    chk("t2_ecnt_last", edge_a, 10);
    tick();
    chk("t2_busy_off", busy_a, 0);

    // Saturation of the 4-bit instance at period 2, then recovery at period 10.
    set_wave(2, 0);
    ticks(10);
    start = 1'b1;
    wait_valid(-1, c);
    chk("t3_ecnt_b", edge_b, 15);
    chk("t3_ovf_b", ovf_b, 1);
    chk("t3_ecnt_a", edge_a, 50);
    chk("t3_ovf_a", ovf_a, 0);
    chk("t3_period_b", period_b, 2);
    set_wave(10, 0);
    ticks(20);
    start = 1'b1;
    wait_valid(-1, c);
    chk("t3b_ecnt_b", edge_b, 10);
    chk("t3b_ovf_b", ovf_b, 0);

    // No activity: zero edges, period held.
    set_wave(0, 0);
    ticks(20);
    start = 1'b1;
    wait_valid(-1, c);
    chk("t4_lat", c, 101);
    chk("t4_ecnt_a", edge_a, 0);
    chk("t4_period_a", period_a, 10);
    chk("t4_pok_a", pok_a, 1);

    // Asynchronous reset mid-gate.
    set_wave(10, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(50);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("midrst");
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    chk("t5_idle_busy", busy_a, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(59, 0) == 0) begin
        case ($urandom_range(3, 0))
          0: set_wave(0, 1'($urandom_range(1, 0)));
          1: set_wave(1, 0);
          default: set_wave(int'($urandom_range(25, 2)), 0);
        endcase
      end
      start = ($urandom_range(39, 0) == 0);
      if ($urandom_range(299, 0) == 0) cont = ~cont;
      if ($urandom_range(1499, 0) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("rnd_rst");
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
